regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Single-write-port scheduler in front of the integer register file.
- Arbitrates up to NREQ writeback producers (ALU, load, mul/div) onto one registered write port (regf_we/rd_s/rd_v) using round-robin.
- Keeps a per-register pending-write scoreboard (reg_busy) that issue logic reads for RAW/WAW stalls.
- Sits between the execute/memory writeback stages and the regfile; its outputs drive the regfile write port directly.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
XLEN, 32, register data width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_valid  input  NREQ  requester i has a writeback pending
req_rd_s  input  5*NREQ  destination index of requester i, slice [5i+4:5i]
req_rd_v  input  XLEN*NREQ  writeback data of requester i, slice [XLEN*i+XLEN-1:XLEN*i]
req_ready  output  NREQ  one-hot (or zero) grant, combinational
wb_stall  input  1  freeze writeback: no grants this cycle
alloc_valid  input  1  issue stage allocates a destination register
alloc_rd_s  input  5  register being allocated
regf_we  output  1  regfile write enable, registered
rd_s  output  5  regfile write index, registered
rd_v  output  XLEN  regfile write data, registered
reg_busy  output  32  pending-write bitmap, bit 0 always 0, registered
sb_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (rst=1 at posedge): regf_we=0, rd_s=0, rd_v=0, reg_busy=0, rr_ptr=0, sb_err=0. Reset mid-operation drops any in-flight grant; no write is emitted the following cycle.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. A requester holds valid/rd_s/rd_v stable until it is granted. req_ready depends on req_valid, rr_ptr and wb_stall only, never on data.
- Arbitration:
  - rr_ptr (clog2(NREQ) bits) names the highest-priority requester.
  - Scan order is rr_ptr, rr_ptr+1, … mod NREQ; the first valid requester is granted. At most one grant per cycle.
  - After a grant to i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr holds.
- wb_stall=1: req_ready all 0, rr_ptr holds, and regf_we=0 next cycle.
- Output stage, 1-cycle latency:
  - On a transfer from i at edge k, at edge k+1: rd_s=req_rd_s[i], rd_v=req_rd_v[i], regf_we=(req_rd_s[i]!=0).
  - A transfer to x0 is consumed (ready asserted) but never writes.
  - With no transfer: regf_we=0; rd_s and rd_v hold their previous values.
- Scoreboard (one bit per register):
  - Set: alloc_valid & alloc_rd_s!=0 sets reg_busy[alloc_rd_s] at the next edge.
  - Clear: a transfer with rd!=0 clears reg_busy[rd] at the same edge that loads the output stage. The bit therefore drops in the cycle regf_we is high; the regfile's write-bypass covers a same-cycle read.
  - Same register set and cleared in the same cycle: set wins (new producer).
  - Allocating an already-busy register is illegal; issue must stall on reg_busy. If it occurs, sb_err <= 1 (sticky until rst) and the bit stays set.
  - Transfer to a non-busy register with rd!=0 also sets sb_err; the write still proceeds.
  - alloc is accepted regardless of wb_stall.
- reg_busy[0] is constant 0. Writes to x0 never touch the scoreboard.

Test Plan:
- Reset: drive all inputs active, pulse rst -> next cycle regf_we=0, rd_s=0, rd_v=0, reg_busy=0, sb_err=0, req_ready=0 while rst high.
- Single write: alloc x5, then req_valid[1] with rd=5, data=0xDEADBEEF -> req_ready=3'b010 same cycle. Next cycle regf_we=1, rd_s=5, rd_v=0xDEADBEEF, reg_busy[5]=0.
- Round-robin: all three valid continuously with rd=1,2,3 (allocated) from reset -> grants 0,1,2,0… one per cycle. regf_we high every cycle after the first, rd_s sequence 1,2,3.
- x0 and stall:
  - req_valid[2] with rd=0 -> granted, regf_we=0 next cycle, reg_busy unchanged.
  - wb_stall=1 for 3 cycles with req_valid[0] held -> req_ready=0, regf_we=0. Grant occurs the cycle stall drops.
- Scoreboard collision: alloc x7 in the same cycle a writeback to x7 transfers -> reg_busy[7]=1 afterwards, sb_err=0 (x7 previously busy).
- Protocol error: alloc x9 twice without writeback -> sb_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the integer regfile write port, plus the
// per-register pending-write scoreboard that issue uses for RAW/WAW stalls.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd_s,
  input  logic [XLEN*NREQ-1:0] req_rd_v,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wb_stall,
  input  logic                 alloc_valid,
  input  logic [4:0]           alloc_rd_s,
  output logic                 regf_we,
  output logic [4:0]           rd_s,
  output logic [XLEN-1:0]      rd_v,
  output logic [31:0]          reg_busy,
  output logic                 sb_err
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_v;
  logic            wr_live, alloc_live, clr_hit, alloc_err, wb_err;
  logic [31:0]     busy_nxt;

  // First valid requester scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (rst || wb_stall) gnt_any = 1'b0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign wb_rd      = req_rd_s[5*gnt_idx +: 5];
  assign wb_v       = req_rd_v[XLEN*gnt_idx +: XLEN];
  assign wr_live    = gnt_any && (wb_rd != 5'd0);
  assign alloc_live = alloc_valid && (alloc_rd_s != 5'd0);
  assign clr_hit    = wr_live && (wb_rd == alloc_rd_s);
  // Re-allocating a register whose producer retires this very cycle is legal.
  assign alloc_err  = alloc_live && reg_busy[alloc_rd_s] && !clr_hit;
  assign wb_err     = wr_live && !reg_busy[wb_rd];

  always_comb begin
    busy_nxt = reg_busy;
    if (wr_live)    busy_nxt[wb_rd]      = 1'b0;
    if (alloc_live) busy_nxt[alloc_rd_s] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regf_we  <= 1'b0;
      rd_s     <= '0;
      rd_v     <= '0;
      reg_busy <= '0;
      rr_ptr   <= '0;
      sb_err   <= 1'b0;
    end else begin
      regf_we  <= wr_live;
      reg_busy <= busy_nxt;
      if (alloc_err || wb_err) sb_err <= 1'b1;
      if (gnt_any) begin
        rd_s   <= wb_rd;
        rd_v   <= wb_v;
        rr_ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a small reference model predicts
// grants and queues the expected write-port result for the following cycle.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk = 0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_rd_s;
  logic [XLEN*NREQ-1:0] req_rd_v;
  logic [NREQ-1:0]      req_ready;
  logic                 wb_stall;
  logic                 alloc_valid;
  logic [4:0]           alloc_rd_s;
  logic                 regf_we;
  logic [4:0]           rd_s;
  logic [XLEN-1:0]      rd_v;
  logic [31:0]          reg_busy;
  logic                 sb_err;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd_s(req_rd_s),
    .req_rd_v(req_rd_v), .req_ready(req_ready), .wb_stall(wb_stall),
    .alloc_valid(alloc_valid), .alloc_rd_s(alloc_rd_s), .regf_we(regf_we),
    .rd_s(rd_s), .rd_v(rd_v), .reg_busy(reg_busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] v;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int              m_ptr;
  logic [31:0]     m_busy;
  logic            m_err;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_v;
  logic [4:0]      rds  [NREQ];
  logic [XLEN-1:0] dats [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      req_rd_s[5*i +: 5]       = rds[i];
      req_rd_v[XLEN*i +: XLEN] = dats[i];
    end
  endtask

  // One clock: check combinational grant, predict, clock, check outputs.
  task automatic step(input string tag);
    logic [NREQ-1:0] exp_rdy;
    wb_exp_t e;
    int g;
    logic live;
    drive_req();
    #1;
    exp_rdy = '0;
    g = -1;
    if (!rst && !wb_stall)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    if (rst) begin
      m_ptr = 0; m_busy = '0; m_err = 0; m_rd = '0; m_v = '0;
      e.we = 0;
    end else begin
      live = (g >= 0) && (rds[g] != 0);
      e.we = live;
      if (g >= 0) begin
        m_rd  = rds[g];
        m_v   = dats[g];
        m_ptr = (g + 1) % NREQ;
        if (live && !m_busy[rds[g]]) m_err = 1;
      end
      if (alloc_valid && alloc_rd_s != 0 && m_busy[alloc_rd_s] &&
          !(live && rds[g] == alloc_rd_s)) m_err = 1;
      if (live) m_busy[rds[g]] = 1'b0;
      if (alloc_valid && alloc_rd_s != 0) m_busy[alloc_rd_s] = 1'b1;
    end
    e.rd = m_rd;
    e.v  = m_v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".we"},   32'(regf_we), 32'(e.we));
    chk({tag, ".rd_s"}, 32'(rd_s),    32'(e.rd));
    chk({tag, ".rd_v"}, rd_v,         e.v);
    chk({tag, ".busy"}, reg_busy,     m_busy);
    chk({tag, ".err"},  32'(sb_err),  32'(m_err));
  endtask

  task automatic idle();
    req_valid = '0; wb_stall = 0; alloc_valid = 0; alloc_rd_s = '0;
  endtask

  initial begin
    m_ptr = 0; m_busy = '0; m_err = 0; m_rd = '0; m_v = '0;
    for (int i = 0; i < NREQ; i++) begin rds[i] = 5'(i + 1); dats[i] = 32'hA0 + i; end
    req_rd_s = '0; req_rd_v = '0;
    // Reset with every input active
    rst = 1; req_valid = '1; wb_stall = 0; alloc_valid = 1; alloc_rd_s = 5'd4;
    @(posedge clk); #1;
    step("rst0");
    step("rst1");
    chk("rst.busy_zero", reg_busy, 32'h0);

    // Single write to x5 via requester 1
    rst = 0; idle();
    alloc_valid = 1; alloc_rd_s = 5'd5;
    step("alloc5");
    chk("alloc5.busy5", 32'(reg_busy[5]), 32'd1);
    idle(); req_valid = 3'b010; rds[1] = 5'd5; dats[1] = 32'hDEADBEEF;
    drive_req(); #1;
    chk("single.ready_const", 32'(req_ready), 32'h2);
    step("single");
    chk("single.rd_v_const", rd_v, 32'hDEADBEEF);
    chk("single.busy5_clr", 32'(reg_busy[5]), 32'd0);

    // Round-robin from a fresh reset, x1..x3 re-allocated as each retires
    idle(); rst = 1;
    step("rr_rst");
    rst = 0;
    for (int r = 1; r <= 3; r++) begin
      alloc_valid = 1; alloc_rd_s = 5'(r);
      step("rr_alloc");
    end
    for (int i = 0; i < NREQ; i++) begin rds[i] = 5'(i + 1); dats[i] = 32'h1000 * (i + 1); end
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      alloc_valid = 1; alloc_rd_s = 5'((c % 3) + 1);
      step("rr");
      chk("rr.rd_seq", 32'(rd_s), 32'((c % 3) + 1));
    end
    chk("rr.no_err", 32'(sb_err), 32'd0);

    // Write to x0: consumed, no write, scoreboard untouched
    idle(); req_valid = 3'b100; rds[2] = 5'd0; dats[2] = 32'h5555;
    step("x0");
    chk("x0.we", 32'(regf_we), 32'd0);

    // Stall for three cycles with requester 0 waiting
    idle(); alloc_valid = 1; alloc_rd_s = 5'd6;
    step("alloc6");
    idle(); req_valid = 3'b001; rds[0] = 5'd6; dats[0] = 32'hCAFE0006; wb_stall = 1;
    for (int c = 0; c < 3; c++) step("stall");
    wb_stall = 0;
    step("unstall");
    chk("unstall.rd_v", rd_v, 32'hCAFE0006);

    // Same-cycle retire and re-allocate of x7
    idle(); alloc_valid = 1; alloc_rd_s = 5'd7;
    step("alloc7");
    req_valid = 3'b010; rds[1] = 5'd7; dats[1] = 32'h77;
    step("collide7");
    chk("collide7.busy7", 32'(reg_busy[7]), 32'd1);
    chk("collide7.err", 32'(sb_err), 32'd0);

    // Double allocation of x9 is a sticky error
    idle(); alloc_valid = 1; alloc_rd_s = 5'd9;
    step("alloc9a");
    step("alloc9b");
    chk("dup9.err", 32'(sb_err), 32'd1);
    idle();
    step("sticky0");
    step("sticky1");
    chk("sticky.err", 32'(sb_err), 32'd1);
    rst = 1;
    step("err_rst");
    chk("err_rst.err", 32'(sb_err), 32'd0);

    // Writeback to a register nobody allocated also flags an error
    rst = 0; idle(); req_valid = 3'b001; rds[0] = 5'd10; dats[0] = 32'hAB;
    step("stray10");
    chk("stray10.err", 32'(sb_err), 32'd1);
    idle();
    step("tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
